// File: rtl/cv32e40s_mpu_req_arbiter.sv
// Purpose : shares one MPU request port between two requesters and routes responses back to their owners.
// Latency : grant and request fields are combinational; responses are routed in the cycle they arrive.
// Backpressure: a stalled request is locked until the MPU accepts it; no new issue once MAX_OUTSTANDING are in flight.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   rX_req_i/addr/we/be/wdata      requester X request channel (X = 0, 1)
//   rX_gnt_o                       requester X request accepted this cycle
//   rX_rvalid_o / rX_err_o         response (and MPU fault flag) for requester X
//   rdata_o                        shared response data, qualified by rX_rvalid_o
//   mpu_*                          muxed request towards the MPU, response from it
//   one_txn_pend_n_o               exactly one transaction outstanding next cycle
//   outstanding_o                  current outstanding count
//   protocol_err_o                 sticky: response arrived with nothing outstanding

// Purpose : in-order ownership FIFO; pointers wrap modulo DEPTH, occupancy tracked by the user.
// Latency : head_dat reflects the oldest entry combinationally; a push is visible from the next cycle.
// Backpressure: none; the user must never push when full or pop when empty.
module fifo_sync #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop_vld,
  output logic [WIDTH-1:0] head_dat
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr_q;
  logic [PW-1:0]    rptr_q;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_vld) wptr_q <= ptr_inc(wptr_q);
      if (pop_vld)  rptr_q <= ptr_inc(rptr_q);
    end
  end

  always_ff @(posedge clk) begin
    if (push_vld) mem[wptr_q] <= push_dat;
  end

  assign head_dat = mem[rptr_q];

endmodule

// Purpose : round-robin MPU request arbiter with in-order response routing for two requesters.
// Latency : zero-cycle grant/mux; responses routed same cycle, earliest one cycle after acceptance.
// Backpressure: holds the selected request stable under !mpu_trans_ready_i; stops issuing at MAX_OUTSTANDING.
module cv32e40s_mpu_req_arbiter #(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned R0_FIRST        = 1
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        r0_req_i,
  output logic        r0_gnt_o,
  input  logic [31:0] r0_addr_i,
  input  logic        r0_we_i,
  input  logic [3:0]  r0_be_i,
  input  logic [31:0] r0_wdata_i,
  output logic        r0_rvalid_o,
  output logic        r0_err_o,

  input  logic        r1_req_i,
  output logic        r1_gnt_o,
  input  logic [31:0] r1_addr_i,
  input  logic        r1_we_i,
  input  logic [3:0]  r1_be_i,
  input  logic [31:0] r1_wdata_i,
  output logic        r1_rvalid_o,
  output logic        r1_err_o,

  output logic [31:0] rdata_o,

  output logic        mpu_trans_valid_o,
  input  logic        mpu_trans_ready_i,
  output logic [31:0] mpu_addr_o,
  output logic        mpu_we_o,
  output logic [3:0]  mpu_be_o,
  output logic [31:0] mpu_wdata_o,
  input  logic        mpu_resp_valid_i,
  input  logic        mpu_resp_err_i,
  input  logic [31:0] mpu_rdata_i,

  output logic        one_txn_pend_n_o,
  output logic [2:0]  outstanding_o,
  output logic        protocol_err_o
);

  localparam logic [2:0] MAX_CNT = 3'(MAX_OUTSTANDING);
  localparam logic       PRIO_RST = (R0_FIRST != 0) ? 1'b0 : 1'b1;

  logic [2:0] cnt_q, cnt_n;
  logic       lock_q, lock_id_q, prio_q, perr_q;
  logic       sel, can_issue, acc, pop, head;

  // A locked request wins unconditionally; otherwise a lone requester wins,
  // and a tie goes to the requester holding priority.
  always_comb begin
    sel = prio_q;
    if (lock_q)                      sel = lock_id_q;
    else if (r0_req_i && !r1_req_i)  sel = 1'b0;
    else if (r1_req_i && !r0_req_i)  sel = 1'b1;
  end

  // Occupancy uses the registered count only: a response popping this cycle
  // does not open a slot until the next one.
  assign can_issue         = (cnt_q < MAX_CNT);
  assign mpu_trans_valid_o = can_issue && (lock_q || r0_req_i || r1_req_i);
  assign acc               = mpu_trans_valid_o && mpu_trans_ready_i;

  assign mpu_addr_o  = sel ? r1_addr_i  : r0_addr_i;
  assign mpu_we_o    = sel ? r1_we_i    : r0_we_i;
  assign mpu_be_o    = sel ? r1_be_i    : r0_be_i;
  assign mpu_wdata_o = sel ? r1_wdata_i : r0_wdata_i;

  assign r0_gnt_o = acc && !sel;
  assign r1_gnt_o = acc &&  sel;

  // Responses with nothing outstanding are dropped and flagged instead.
  assign pop = mpu_resp_valid_i && (cnt_q != 3'd0);

  fifo_sync #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (1)
  ) u_id_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_vld (acc),
    .push_dat (sel),
    .pop_vld  (pop),
    .head_dat (head)
  );

  assign r0_rvalid_o = pop && !head;
  assign r1_rvalid_o = pop &&  head;
  assign r0_err_o    = pop && !head && mpu_resp_err_i;
  assign r1_err_o    = pop &&  head && mpu_resp_err_i;
  assign rdata_o     = pop ? mpu_rdata_i : 32'h0;

  assign cnt_n            = cnt_q + {2'b00, acc} - {2'b00, pop};
  assign one_txn_pend_n_o = (cnt_n == 3'd1);
  assign outstanding_o    = cnt_q;
  assign protocol_err_o   = perr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= 3'd0;
      lock_q    <= 1'b0;
      lock_id_q <= 1'b0;
      prio_q    <= PRIO_RST;
      perr_q    <= 1'b0;
    end else begin
      cnt_q <= cnt_n;
      if (acc) begin
        lock_q <= 1'b0;
        prio_q <= !sel;
      end else if (mpu_trans_valid_o) begin
        lock_q    <= 1'b1;
        lock_id_q <= sel;
      end
      if (mpu_resp_valid_i && (cnt_q == 3'd0)) perr_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cv32e40s_mpu_req_arbiter.sv
module tb_cv32e40s_mpu_req_arbiter;

  logic        clk;
  logic        rst_n;
  logic        r0_req_i, r1_req_i;
  logic        r0_gnt_o, r1_gnt_o;
  logic [31:0] r0_addr_i, r1_addr_i;
  logic        r0_we_i, r1_we_i;
  logic [3:0]  r0_be_i, r1_be_i;
  logic [31:0] r0_wdata_i, r1_wdata_i;
  logic        r0_rvalid_o, r1_rvalid_o;
  logic        r0_err_o, r1_err_o;
  logic [31:0] rdata_o;
  logic        mpu_trans_valid_o;
  logic        mpu_trans_ready_i;
  logic [31:0] mpu_addr_o;
  logic        mpu_we_o;
  logic [3:0]  mpu_be_o;
  logic [31:0] mpu_wdata_o;
  logic        mpu_resp_valid_i;
  logic        mpu_resp_err_i;
  logic [31:0] mpu_rdata_i;
  logic        one_txn_pend_n_o;
  logic [2:0]  outstanding_o;
  logic        protocol_err_o;

  int n_checks = 0;
  int n_errors = 0;

  cv32e40s_mpu_req_arbiter #(
    .MAX_OUTSTANDING (2),
    .R0_FIRST        (1)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .r0_req_i          (r0_req_i),
    .r0_gnt_o          (r0_gnt_o),
    .r0_addr_i         (r0_addr_i),
    .r0_we_i           (r0_we_i),
    .r0_be_i           (r0_be_i),
    .r0_wdata_i        (r0_wdata_i),
    .r0_rvalid_o       (r0_rvalid_o),
    .r0_err_o          (r0_err_o),
    .r1_req_i          (r1_req_i),
    .r1_gnt_o          (r1_gnt_o),
    .r1_addr_i         (r1_addr_i),
    .r1_we_i           (r1_we_i),
    .r1_be_i           (r1_be_i),
    .r1_wdata_i        (r1_wdata_i),
    .r1_rvalid_o       (r1_rvalid_o),
    .r1_err_o          (r1_err_o),
    .rdata_o           (rdata_o),
    .mpu_trans_valid_o (mpu_trans_valid_o),
    .mpu_trans_ready_i (mpu_trans_ready_i),
    .mpu_addr_o        (mpu_addr_o),
    .mpu_we_o          (mpu_we_o),
    .mpu_be_o          (mpu_be_o),
    .mpu_wdata_o       (mpu_wdata_o),
    .mpu_resp_valid_i  (mpu_resp_valid_i),
    .mpu_resp_err_i    (mpu_resp_err_i),
    .mpu_rdata_i       (mpu_rdata_i),
    .one_txn_pend_n_o  (one_txn_pend_n_o),
    .outstanding_o     (outstanding_o),
    .protocol_err_o    (protocol_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive_idle();
    r0_req_i = 0; r0_addr_i = 0; r0_we_i = 0; r0_be_i = 0; r0_wdata_i = 0;
    r1_req_i = 0; r1_addr_i = 0; r1_we_i = 0; r1_be_i = 0; r1_wdata_i = 0;
    mpu_trans_ready_i = 0; mpu_resp_valid_i = 0; mpu_resp_err_i = 0; mpu_rdata_i = 0;
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive_idle();
    rst_n = 0;
    next_cycle();
    next_cycle();
    rst_n = 1;
  endtask

  initial begin
    drive_idle();
    rst_n = 0;
    #3;
    check("rst_valid",  {31'b0, mpu_trans_valid_o}, 32'd0);
    check("rst_gnt",    {30'b0, r1_gnt_o, r0_gnt_o}, 32'd0);
    check("rst_rvalid", {30'b0, r1_rvalid_o, r0_rvalid_o}, 32'd0);
    check("rst_err",    {29'b0, protocol_err_o, r1_err_o, r0_err_o}, 32'd0);
    check("rst_cnt",    {29'b0, outstanding_o}, 32'd0);
    check("rst_pend",   {31'b0, one_txn_pend_n_o}, 32'd0);
    check("rst_rdata",  rdata_o, 32'd0);
    do_reset();

    // Single r0 read
    r0_req_i = 1; r0_addr_i = 32'h100; mpu_trans_ready_i = 1;
    mid();
    check("t1_gnt0",  {31'b0, r0_gnt_o}, 32'd1);
    check("t1_gnt1",  {31'b0, r1_gnt_o}, 32'd0);
    check("t1_addr",  mpu_addr_o, 32'h100);
    check("t1_pend0", {31'b0, one_txn_pend_n_o}, 32'd1);
    check("t1_cnt0",  {29'b0, outstanding_o}, 32'd0);
    next_cycle();
    r0_req_i = 0;
    mid();
    check("t1_cnt1",  {29'b0, outstanding_o}, 32'd1);
    check("t1_rv_early", {31'b0, r0_rvalid_o}, 32'd0);
    next_cycle();
    mpu_resp_valid_i = 1; mpu_rdata_i = 32'hDEADBEEF;
    mid();
    check("t1_rvalid0", {31'b0, r0_rvalid_o}, 32'd1);
    check("t1_rvalid1", {31'b0, r1_rvalid_o}, 32'd0);
    check("t1_err0",    {31'b0, r0_err_o}, 32'd0);
    check("t1_rdata",   rdata_o, 32'hDEADBEEF);
    check("t1_pend2",   {31'b0, one_txn_pend_n_o}, 32'd0);
    next_cycle();
    mpu_resp_valid_i = 0;
    mid();
    check("t1_cnt3", {29'b0, outstanding_o}, 32'd0);

    // Both requesting, responses one cycle after each accept
    do_reset();
    r0_req_i = 1; r0_addr_i = 32'h200;
    r1_req_i = 1; r1_addr_i = 32'h300;
    mpu_trans_ready_i = 1;
    for (int k = 0; k < 5; k++) begin
      mpu_resp_valid_i = (k >= 1);
      mpu_rdata_i = 32'(k) + 32'h1000;
      mid();
      check($sformatf("t2_gnt0_c%0d", k), {31'b0, r0_gnt_o}, {31'b0, (k % 2 == 0)});
      check($sformatf("t2_gnt1_c%0d", k), {31'b0, r1_gnt_o}, {31'b0, (k % 2 == 1)});
      check($sformatf("t2_addr_c%0d", k), mpu_addr_o, (k % 2 == 0) ? 32'h200 : 32'h300);
      check($sformatf("t2_cnt_c%0d", k), {29'b0, outstanding_o}, (k == 0) ? 32'd0 : 32'd1);
      if (k >= 1) begin
        check($sformatf("t2_rv0_c%0d", k), {31'b0, r0_rvalid_o}, {31'b0, (k % 2 == 1)});
        check($sformatf("t2_rv1_c%0d", k), {31'b0, r1_rvalid_o}, {31'b0, (k % 2 == 0)});
        check($sformatf("t2_rdata_c%0d", k), rdata_o, 32'(k) + 32'h1000);
      end
      next_cycle();
    end
    r0_req_i = 0; r1_req_i = 0;
    mid();
    check("t2_drain_rv0", {31'b0, r0_rvalid_o}, 32'd1);
    next_cycle();
    mpu_resp_valid_i = 0;
    mid();
    check("t2_cnt_end", {29'b0, outstanding_o}, 32'd0);

    // Backpressure: r1 locked while r0 arrives later
    do_reset();
    r1_req_i = 1; r1_addr_i = 32'h400; r1_we_i = 1; r1_be_i = 4'hC; r1_wdata_i = 32'hA5A5A5A5;
    r0_addr_i = 32'h500;
    for (int k = 0; k < 3; k++) begin
      if (k == 1) r0_req_i = 1;
      mid();
      check($sformatf("t3_valid_c%0d", k), {31'b0, mpu_trans_valid_o}, 32'd1);
      check($sformatf("t3_addr_c%0d", k), mpu_addr_o, 32'h400);
      check($sformatf("t3_gnt_c%0d", k), {30'b0, r1_gnt_o, r0_gnt_o}, 32'd0);
      next_cycle();
    end
    mpu_trans_ready_i = 1;
    mid();
    check("t3_gnt1",  {31'b0, r1_gnt_o}, 32'd1);
    check("t3_gnt0",  {31'b0, r0_gnt_o}, 32'd0);
    check("t3_addr3", mpu_addr_o, 32'h400);
    check("t3_we",    {31'b0, mpu_we_o}, 32'd1);
    check("t3_be",    {28'b0, mpu_be_o}, 32'hC);
    check("t3_wdata", mpu_wdata_o, 32'hA5A5A5A5);
    next_cycle();
    r1_req_i = 0;
    mid();
    check("t3_gnt0_next", {31'b0, r0_gnt_o}, 32'd1);
    check("t3_addr4",     mpu_addr_o, 32'h500);
    next_cycle();
    r0_req_i = 0; mpu_resp_valid_i = 1;
    mid();
    check("t3_resp1", {30'b0, r1_rvalid_o, r0_rvalid_o}, 32'd2);
    next_cycle();
    mid();
    check("t3_resp0", {30'b0, r1_rvalid_o, r0_rvalid_o}, 32'd1);
    next_cycle();
    mpu_resp_valid_i = 0;
    mid();
    check("t3_cnt_end", {29'b0, outstanding_o}, 32'd0);

    // Full limit with MAX_OUTSTANDING = 2
    do_reset();
    r0_req_i = 1; r0_addr_i = 32'h600; mpu_trans_ready_i = 1;
    next_cycle();
    next_cycle();
    mid();
    check("t4_cnt_full", {29'b0, outstanding_o}, 32'd2);
    check("t4_valid_full", {31'b0, mpu_trans_valid_o}, 32'd0);
    check("t4_gnt_full", {31'b0, r0_gnt_o}, 32'd0);
    check("t4_pend_full", {31'b0, one_txn_pend_n_o}, 32'd0);
    next_cycle();
    mpu_resp_valid_i = 1;
    mid();
    check("t4_valid_N", {31'b0, mpu_trans_valid_o}, 32'd0);
    check("t4_rv_N", {31'b0, r0_rvalid_o}, 32'd1);
    check("t4_pend_N", {31'b0, one_txn_pend_n_o}, 32'd1);
    next_cycle();
    mpu_resp_valid_i = 0;
    mid();
    check("t4_valid_N1", {31'b0, mpu_trans_valid_o}, 32'd1);
    check("t4_gnt_N1", {31'b0, r0_gnt_o}, 32'd1);
    check("t4_pend_N1", {31'b0, one_txn_pend_n_o}, 32'd0);
    next_cycle();
    r0_req_i = 0; mpu_resp_valid_i = 1;
    next_cycle();
    next_cycle();
    mpu_resp_valid_i = 0;
    mid();
    check("t4_cnt_end", {29'b0, outstanding_o}, 32'd0);
    check("t4_perr", {31'b0, protocol_err_o}, 32'd0);

    // MPU fault on an r1 write
    do_reset();
    r1_req_i = 1; r1_we_i = 1; r1_addr_i = 32'h700; mpu_trans_ready_i = 1;
    mid();
    check("t5_gnt1", {31'b0, r1_gnt_o}, 32'd1);
    next_cycle();
    r1_req_i = 0; mpu_resp_valid_i = 1; mpu_resp_err_i = 1;
    mid();
    check("t5_rv1",  {31'b0, r1_rvalid_o}, 32'd1);
    check("t5_err1", {31'b0, r1_err_o}, 32'd1);
    check("t5_r0",   {30'b0, r0_err_o, r0_rvalid_o}, 32'd0);
    next_cycle();
    mpu_resp_valid_i = 0; mpu_resp_err_i = 0;

    // Spurious response with nothing outstanding
    mpu_resp_valid_i = 1;
    mid();
    check("t6_rv", {30'b0, r1_rvalid_o, r0_rvalid_o}, 32'd0);
    check("t6_perr_same", {31'b0, protocol_err_o}, 32'd0);
    next_cycle();
    mpu_resp_valid_i = 0;
    mid();
    check("t6_perr_set", {31'b0, protocol_err_o}, 32'd1);
    check("t6_cnt", {29'b0, outstanding_o}, 32'd0);
    next_cycle();
    next_cycle();
    mid();
    check("t6_perr_sticky", {31'b0, protocol_err_o}, 32'd1);
    rst_n = 0;
    #1;
    check("t6_perr_rst", {31'b0, protocol_err_o}, 32'd0);
    next_cycle();
    rst_n = 1;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
